// File: rtl/proc_pkg.sv
// Shared R-type encoding constants, field positions and sequencer state encoding.
package proc_pkg;

  localparam int unsigned XLEN = 32;

  // Instruction field bit positions
  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned FunctMsb  = 5;
  localparam int unsigned FunctLsb  = 0;

  localparam logic [5:0] OpRtype   = 6'h00;
  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StRead   = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4
  } state_e;

  function automatic logic [5:0] get_opcode(input logic [XLEN-1:0] word);
    return word[OpcodeMsb:OpcodeLsb];
  endfunction

  function automatic logic [4:0] get_rs(input logic [XLEN-1:0] word);
    return word[RsMsb:RsLsb];
  endfunction

  function automatic logic [4:0] get_rt(input logic [XLEN-1:0] word);
    return word[RtMsb:RtLsb];
  endfunction

  function automatic logic [4:0] get_rd(input logic [XLEN-1:0] word);
    return word[RdMsb:RdLsb];
  endfunction

  function automatic logic [5:0] get_funct(input logic [XLEN-1:0] word);
    return word[FunctMsb:FunctLsb];
  endfunction

endpackage

// File: rtl/alu_rtype.sv
// Combinational R-type ALU: ADD/SUB wrap, AND/OR bitwise, SLT signed compare.
module alu_rtype
  import proc_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      funct,
  output logic [XLEN-1:0] result,
  output logic            valid_funct
);

  always_comb begin
    result      = '0;
    valid_funct = 1'b0;
    case (funct)
      FunctAdd: begin
        result      = a + b;
        valid_funct = 1'b1;
      end
      FunctSub: begin
        result      = a - b;
        valid_funct = 1'b1;
      end
      FunctAnd: begin
        result      = a & b;
        valid_funct = 1'b1;
      end
      FunctOr: begin
        result      = a | b;
        valid_funct = 1'b1;
      end
      FunctSlt: begin
        result      = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        valid_funct = 1'b1;
      end
      default: begin
        result      = '0;
        valid_funct = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: IDLE -> DECODE -> READ -> EXEC -> WB, one cycle per state.
module rtype_sequencer
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  input  logic [XLEN-1:0] rf_a,
  input  logic [XLEN-1:0] rf_b,
  output logic [XLEN-1:0] wb_data,
  output logic            rf_we,
  output logic            done,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  logic [XLEN-1:0] alu_result;
  logic            alu_valid;
  logic            legal;

  alu_rtype u_alu (
    .a           (opa_q),
    .b           (opb_q),
    .funct       (get_funct(ir_q)),
    .result      (alu_result),
    .valid_funct (alu_valid)
  );

  assign legal = (get_opcode(ir_q) == OpRtype) && alu_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (instr_valid) state_d = StDecode;
      StDecode: state_d = legal ? StRead : StIdle;
      StRead:   state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Pulse lands in the cycle after DECODE, alongside the return to IDLE.
      illegal_q <= (state_q == StDecode) && !legal;
      if (state_q == StIdle && instr_valid) ir_q <= instr;
      if (state_q == StRead) begin
        opa_q <= rf_a;
        opb_q <= rf_b;
      end
      if (state_q == StExec) result_q <= alu_result;
    end
  end

  // Outputs depend only on state and registers; instr never reaches an output directly.
  always_comb begin
    instr_ready = (state_q == StIdle);
    rs          = '0;
    rt          = '0;
    rd          = '0;
    rf_we       = 1'b0;
    done        = 1'b0;
    wb_data     = result_q;
    illegal     = illegal_q;
    if (state_q != StIdle) begin
      rs = get_rs(ir_q);
      rt = get_rt(ir_q);
    end
    // rd stays on the discard register unless we are actually writing back.
    if (state_q == StWb) begin
      rd    = get_rd(ir_q);
      rf_we = 1'b1;
      done  = 1'b1;
    end
  end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed-vector bench for rtype_sequencer with hand-computed expectations.
module tb_rtype_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rf_a, rf_b;
  logic [31:0] wb_data;
  logic        rf_we, done, illegal;

  int vectors;
  int miscompares;

  // Observations captured while an instruction walks through the pipeline
  logic        c_ready0, c_ready_next, c_done_after, c_early_we, c_illegal_any;
  logic [4:0]  c_rs, c_rt, c_rd_dec, c_rd_exec, c_rd_wb;
  logic [31:0] c_wb;
  logic        c_we_wb, c_done_wb, c_ready_wb;

  rtype_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .rf_a        (rf_a),
    .rf_b        (rf_b),
    .wb_data     (wb_data),
    .rf_we       (rf_we),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction in IDLE (cycle N) and record outputs through N+5.
  task automatic issue(input logic [31:0] word, input logic [31:0] a, input logic [31:0] b);
    c_ready0    = instr_ready;
    instr       = word;
    instr_valid = 1'b1;
    step();                                   // N+1 DECODE
    instr_valid = 1'b0;
    instr       = 32'h0;
    c_rs = rs; c_rt = rt; c_rd_dec = rd;
    c_early_we = rf_we | done;
    c_illegal_any = illegal;
    rf_a = a; rf_b = b;
    step();                                   // N+2 READ
    c_early_we = c_early_we | rf_we | done;
    c_illegal_any = c_illegal_any | illegal;
    step();                                   // N+3 EXEC
    c_rd_exec = rd;
    c_early_we = c_early_we | rf_we | done;
    c_illegal_any = c_illegal_any | illegal;
    step();                                   // N+4 WB
    c_rd_wb = rd; c_wb = wb_data; c_we_wb = rf_we; c_done_wb = done;
    c_ready_wb = instr_ready;
    c_illegal_any = c_illegal_any | illegal;
    step();                                   // N+5
    c_ready_next = instr_ready;
    c_done_after = done | rf_we;
    rf_a = 32'h0; rf_b = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; rf_a = 32'h0; rf_b = 32'h0;
    step(); step();
    vectors++; if ({rs, rt, rd} !== 15'h0) begin miscompares++;
      $display("FAIL reset_sel: got rs=%0d rt=%0d rd=%0d, want 0 0 0", rs, rt, rd); end
    vectors++; if ({wb_data, rf_we, done, illegal} !== 35'h0) begin miscompares++;
      $display("FAIL reset_out: got wb=%h we=%b done=%b ill=%b, want all 0",
               wb_data, rf_we, done, illegal); end
    rst = 1'b0;
    #1;
    vectors++; if (instr_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_ready: got %b, want 1", instr_ready); end
  endtask

  task automatic test_add();
    issue(32'h00842020, 32'd5, 32'd5);
    vectors++; if (c_ready0 !== 1'b1) begin miscompares++;
      $display("FAIL add_ready: got %b, want 1", c_ready0); end
    vectors++; if ({c_rs, c_rt} !== {5'd4, 5'd4}) begin miscompares++;
      $display("FAIL add_rs_rt: got %0d %0d, want 4 4", c_rs, c_rt); end
    vectors++; if ({c_rd_dec, c_rd_exec} !== 10'd0) begin miscompares++;
      $display("FAIL add_rd_early: got dec=%0d exec=%0d, want 0 0", c_rd_dec, c_rd_exec); end
    vectors++; if (c_early_we !== 1'b0) begin miscompares++;
      $display("FAIL add_early_we: got %b, want 0", c_early_we); end
    vectors++; if ({c_rd_wb, c_wb, c_we_wb, c_done_wb} !== {5'd4, 32'd10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add_wb: got rd=%0d wb=%h we=%b done=%b, want 4 0000000a 1 1",
               c_rd_wb, c_wb, c_we_wb, c_done_wb); end
    vectors++; if ({c_ready_wb, c_ready_next, c_done_after} !== 3'b010) begin miscompares++;
      $display("FAIL add_latency: got ready_wb=%b ready_next=%b done_after=%b, want 0 1 0",
               c_ready_wb, c_ready_next, c_done_after); end
  endtask

  task automatic test_sub();
    issue(32'h00221822, 32'd0, 32'd1);
    vectors++; if ({c_rs, c_rt, c_rd_wb} !== {5'd1, 5'd2, 5'd3}) begin miscompares++;
      $display("FAIL sub_sel: got rs=%0d rt=%0d rd=%0d, want 1 2 3", c_rs, c_rt, c_rd_wb); end
    vectors++; if (c_wb !== 32'hFFFF_FFFF) begin miscompares++;
      $display("FAIL sub_wrap: got %h, want ffffffff", c_wb); end
  endtask

  task automatic test_slt();
    issue(32'h00A6382A, 32'hFFFF_FFFF, 32'd1);
    vectors++; if ({c_rs, c_rt, c_rd_wb} !== {5'd5, 5'd6, 5'd7}) begin miscompares++;
      $display("FAIL slt_sel: got rs=%0d rt=%0d rd=%0d, want 5 6 7", c_rs, c_rt, c_rd_wb); end
    vectors++; if (c_wb !== 32'd1) begin miscompares++;
      $display("FAIL slt_neg_lt: got %h, want 00000001", c_wb); end
    issue(32'h00A6382A, 32'd1, 32'hFFFF_FFFF);
    vectors++; if (c_wb !== 32'd0) begin miscompares++;
      $display("FAIL slt_pos_ge: got %h, want 00000000", c_wb); end
    issue(32'h00A6382A, 32'd3, 32'd9);
    vectors++; if (c_wb !== 32'd1) begin miscompares++;
      $display("FAIL slt_small: got %h, want 00000001", c_wb); end
  endtask

  task automatic test_logic();
    issue(32'h00432024, 32'hF0F0_1234, 32'h0FF0_FF00);
    vectors++; if ({c_rd_wb, c_wb} !== {5'd4, 32'h00F0_1200}) begin miscompares++;
      $display("FAIL and: got rd=%0d wb=%h, want 4 00f01200", c_rd_wb, c_wb); end
    issue(32'h00432025, 32'hF0F0_1234, 32'h0FF0_FF00);
    vectors++; if (c_wb !== 32'hFFF0_FF34) begin miscompares++;
      $display("FAIL or: got %h, want fff0ff34", c_wb); end
  endtask

  task automatic test_rd_zero();
    issue(32'h00210020, 32'd7, 32'd8);
    vectors++; if ({c_rd_wb, c_wb, c_we_wb, c_done_wb} !== {5'd0, 32'd15, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL rd_zero: got rd=%0d wb=%h we=%b done=%b, want 0 0000000f 1 1",
               c_rd_wb, c_wb, c_we_wb, c_done_wb); end
  endtask

  task automatic test_illegal(input logic [31:0] word, input string name);
    logic ill1, ill2, ill3, rdy2, we_any;
    instr = word; instr_valid = 1'b1;
    step();                                   // N+1 DECODE
    instr_valid = 1'b0;
    ill1 = illegal; we_any = rf_we | done;
    step();                                   // N+2 back in IDLE
    ill2 = illegal; rdy2 = instr_ready; we_any = we_any | rf_we | done;
    step();                                   // N+3
    ill3 = illegal; we_any = we_any | rf_we | done;
    step(); we_any = we_any | rf_we | done;
    step(); we_any = we_any | rf_we | done;
    vectors++; if ({ill1, ill2, ill3} !== 3'b010) begin miscompares++;
      $display("FAIL %s_pulse: got N+1..3=%b%b%b, want 010", name, ill1, ill2, ill3); end
    vectors++; if (rdy2 !== 1'b1) begin miscompares++;
      $display("FAIL %s_ready: got %b, want 1", name, rdy2); end
    vectors++; if (we_any !== 1'b0) begin miscompares++;
      $display("FAIL %s_no_we: got %b, want 0", name, we_any); end
  endtask

  task automatic test_back_to_back();
    int accepts [$];
    instr = 32'h00842020; instr_valid = 1'b1; rf_a = 32'd1; rf_b = 32'd2;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid && instr_ready) accepts.push_back(i);
      step();
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rf_a = 32'h0; rf_b = 32'h0;
    vectors++; if (accepts.size() !== 2) begin miscompares++;
      $display("FAIL busy_count: got %0d accepts, want 2", accepts.size()); end
    else begin
      vectors++; if ({accepts[0], accepts[1]} !== {32'd0, 32'd5}) begin miscompares++;
        $display("FAIL busy_cycles: got %0d,%0d, want 0,5", accepts[0], accepts[1]); end
    end
  endtask

  task automatic test_reset_exec();
    logic done_seen;
    instr = 32'h00842020; instr_valid = 1'b1; rf_a = 32'd5; rf_b = 32'd5;
    step(); instr_valid = 1'b0;               // DECODE
    step();                                   // READ
    step();                                   // EXEC
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if ({instr_ready, rf_we, done, illegal} !== 4'b1000) begin miscompares++;
      $display("FAIL rst_exec_ctrl: got ready=%b we=%b done=%b ill=%b, want 1 0 0 0",
               instr_ready, rf_we, done, illegal); end
    vectors++; if ({rs, rt, rd, wb_data} !== 47'h0) begin miscompares++;
      $display("FAIL rst_exec_data: got rs=%0d rt=%0d rd=%0d wb=%h, want 0 0 0 0",
               rs, rt, rd, wb_data); end
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); done_seen = done_seen | done | rf_we; end
    vectors++; if (done_seen !== 1'b0) begin miscompares++;
      $display("FAIL rst_exec_no_done: got %b, want 0", done_seen); end
    rf_a = 32'h0; rf_b = 32'h0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_rd_zero();
    test_illegal(32'h8C000000, "ill_opcode");
    test_illegal(32'h00432021, "ill_funct");
    test_back_to_back();
    test_reset_exec();
    test_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
